// File: rtl/nf2401_seq_pkg.sv
// Shared types and constants for the nRF2401 configuration/shift sequencer.
package nf2401_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      RX_WAIT,
      BIT_LO,
      BIT_HI,
      HOLD
   } state_t;

   typedef enum logic [1:0] {
      M_CFG,
      M_TX,
      M_RX
   } mode_t;

   localparam logic [2:0] A_TXDATA = 3'd0;
   localparam logic [2:0] A_RXDATA = 3'd1;
   localparam logic [2:0] A_LEN    = 3'd2;
   localparam logic [2:0] A_CMD    = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;
   localparam logic [2:0] A_IRQEN  = 3'd5;

   localparam logic [7:0] CMD_ABORT  = 8'd0;
   localparam logic [7:0] CMD_CONFIG = 8'd1;
   localparam logic [7:0] CMD_TX     = 8'd2;
   localparam logic [7:0] CMD_RX     = 8'd3;

endpackage

// File: rtl/nf2401_seq_buf.sv
// Byte buffer: one synchronous write port, one asynchronous read port.
module nf2401_seq_buf
   import nf2401_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/nf2401_sequencer.sv
// Bus-mapped sequencer that shifts a byte buffer to/from an nRF2401 over its
// 3-wire CS/CE, CLK1, DATA interface.
module nf2401_sequencer
   import nf2401_seq_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned CS_SETUP  = 8,
   parameter int unsigned BUF_DEPTH = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] address,
   input  logic       chipselect,
   input  logic       write_n,
   input  logic       read_n,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       irq,
   output logic       nrf_cs,
   output logic       nrf_ce,
   output logic       nrf_clk1,
   output logic       nrf_data_o,
   output logic       nrf_data_oe,
   input  logic       nrf_data_i,
   input  logic       nrf_dr1
);

   localparam int unsigned AW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned PW   = $clog2(BUF_DEPTH + 1);
   localparam int unsigned CMAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [PW-1:0] DEPTH_P    = PW'(BUF_DEPTH);
   localparam logic [7:0]    DEPTH_8    = 8'(BUF_DEPTH);

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [PW-1:0] byte_q, byte_d;
   logic [PW-1:0] len_q, wptr_q, rptr_q;
   logic          irqen_q, done_q, err_q, ovf_q;
   logic          load_bit, sample, finish;

   logic          wr_en, rd_en, busy;
   logic          wr_cmd, cmd_abort, cmd_start, start_ok, start_err;
   logic          tx_accept, rx_hit;
   logic          buf_we;
   logic [AW-1:0] buf_waddr, buf_raddr;
   logic [7:0]    buf_wdata, buf_rdata, eng_wdata;

   assign wr_en     = chipselect & ~write_n;
   assign rd_en     = chipselect & ~read_n;
   assign busy      = (state_q != IDLE);
   assign wr_cmd    = wr_en && (address == A_CMD);
   assign cmd_abort = wr_cmd && (writedata == CMD_ABORT);
   assign cmd_start = wr_cmd && ((writedata == CMD_CONFIG) || (writedata == CMD_TX) ||
                                 (writedata == CMD_RX));
   assign start_err = cmd_start && (busy || (len_q == '0));
   assign start_ok  = cmd_start && !start_err;

   // An RX bit write owns the buffer write port; a coincident TXDATA write is not taken.
   assign tx_accept = wr_en && (address == A_TXDATA) && !sample && (wptr_q < DEPTH_P);
   assign rx_hit    = rd_en && (address == A_RXDATA) && !busy && (rptr_q < len_q);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      byte_d   = byte_q;
      load_bit = 1'b0;
      sample   = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_ok) begin
               if (writedata == CMD_CONFIG)  mode_d = M_CFG;
               else if (writedata == CMD_TX) mode_d = M_TX;
               else                          mode_d = M_RX;
               state_d = (writedata == CMD_RX) ? RX_WAIT : SETUP;
            end
         end
         RX_WAIT: begin
            cnt_d = '0;
            if (nrf_dr1) state_d = SETUP;
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d  = BIT_LO;
               cnt_d    = '0;
               bit_d    = '0;
               byte_d   = '0;
               load_bit = 1'b1;
            end
         end
         BIT_LO: begin
            if (cnt_q == DIV_LAST) begin
               state_d = BIT_HI;
               cnt_d   = '0;
            end
         end
         BIT_HI: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               sample = (mode_q == M_RX);
               if (bit_q == 3'd7 && (byte_q + PW'(1)) == len_q) begin
                  state_d = HOLD;
               end else begin
                  state_d  = BIT_LO;
                  load_bit = 1'b1;
                  bit_d    = bit_q + 3'd1;
                  if (bit_q == 3'd7) byte_d = byte_q + PW'(1);
               end
            end
         end
         HOLD: begin
            if (cnt_q == DIV_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               finish  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cmd_abort) begin
         state_d  = IDLE;
         cnt_d    = '0;
         load_bit = 1'b0;
         sample   = 1'b0;
         finish   = 1'b0;
      end
   end

   always_comb begin
      eng_wdata          = buf_rdata;
      eng_wdata[~bit_q]  = nrf_data_i;
   end

   // TX looks ahead to the byte about to be shifted; RX rewrites the byte being sampled.
   assign buf_raddr = !busy ? rptr_q[AW-1:0] :
                      (mode_q == M_RX) ? byte_q[AW-1:0] : byte_d[AW-1:0];
   assign buf_we    = sample | tx_accept;
   assign buf_waddr = sample ? byte_q[AW-1:0] : wptr_q[AW-1:0];
   assign buf_wdata = sample ? eng_wdata : writedata;

   nf2401_seq_buf #(
      .DEPTH (BUF_DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (buf_wdata),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mode_q      <= M_CFG;
         cnt_q       <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         nrf_cs      <= 1'b0;
         nrf_ce      <= 1'b0;
         nrf_data_oe <= 1'b0;
         nrf_clk1    <= 1'b0;
         nrf_data_o  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         nrf_cs      <= (state_d != IDLE) && (mode_d == M_CFG);
         nrf_ce      <= (state_d != IDLE) && (mode_d != M_CFG);
         nrf_data_oe <= (state_d != IDLE) && (mode_d != M_RX);
         nrf_clk1    <= (state_d == BIT_HI);
         if (state_d == IDLE)                  nrf_data_o <= 1'b0;
         else if (load_bit && mode_q != M_RX) nrf_data_o <= buf_rdata[~bit_d];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q    <= '0;
         irqen_q  <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         if (wr_en && address == A_LEN && !busy)
            len_q <= (writedata > DEPTH_8) ? DEPTH_P : writedata[PW-1:0];
         if (wr_en && address == A_IRQEN) irqen_q <= writedata[0];

         if (finish && mode_q != M_RX) wptr_q <= '0;
         else if (tx_accept)           wptr_q <= wptr_q + PW'(1);
         if (finish && mode_q == M_RX) rptr_q <= '0;
         else if (rx_hit)              rptr_q <= rptr_q + PW'(1);

         if (finish)                                          done_q <= 1'b1;
         else if (wr_en && address == A_STATUS && writedata[1]) done_q <= 1'b0;
         if (start_err)                                       err_q <= 1'b1;
         else if (wr_en && address == A_STATUS && writedata[3]) err_q <= 1'b0;
         if (wr_en && address == A_TXDATA && wptr_q >= DEPTH_P) ovf_q <= 1'b1;
         else if (wr_en && address == A_STATUS && writedata[4]) ovf_q <= 1'b0;

         irq <= done_q & irqen_q;

         if (rd_en) begin
            case (address)
               A_RXDATA: readdata <= rx_hit ? buf_rdata : 8'h00;
               A_LEN:    readdata <= 8'(len_q);
               A_STATUS: readdata <= {3'b000, ovf_q, err_q, nrf_dr1, done_q, busy};
               A_IRQEN:  readdata <= {7'b0000000, irqen_q};
               default:  readdata <= 8'h00;
            endcase
         end
      end
   end

endmodule

// File: doc/nf2401_sequencer.md
NF2401_SEQUENCER -- requirements
Module: nf2401_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, 4, system clocks per CLK1 half-period (2..255).
REQ-002 SHALL have parameter CS_SETUP, 8, clocks between CS/CE rise and first data bit.
REQ-003 SHALL have parameter BUF_DEPTH, 32, byte buffer depth.
REQ-004 Ports (name direction width meaning), one per line:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low
- read_n  in  1  read strobe, active-low
- writedata  in  8  write data
- readdata  out  8  registered read data
- irq  out  1  done interrupt
- nrf_cs  out  1  config chip select
- nrf_ce  out  1  chip enable
- nrf_clk1  out  1  serial clock
- nrf_data_o  out  1  serial data out
- nrf_data_oe  out  1  DATA pin drive enable
- nrf_data_i  in  1  serial data in
- nrf_dr1  in  1  data ready

Function
REQ-005 Register map SHALL be: 0 TXDATA (W), 1 RXDATA (R), 2 LEN (R/W, 6 bits), 3 CMD (W; 0 ABORT, 1 CONFIG, 2 TX, 3 RX), 4 STATUS (R: [0] busy, [1] done, [2] dr1, [3] err, [4] ovf; W1C on [1], [3], [4]), 5 IRQEN (R/W bit 0).
- readdata SHALL be registered: value for cycle-N access appears at N+1.
REQ-006 A TXDATA write SHALL store the byte at buf[wptr] and increment wptr; a write at wptr==BUF_DEPTH SHALL be dropped and set ovf.
REQ-007 A RXDATA read SHALL return buf[rptr] and increment rptr; at rptr==LEN it SHALL return 0 without incrementing.
REQ-008 LEN writes above BUF_DEPTH SHALL clamp to BUF_DEPTH; CMD 1–3 with LEN==0, or issued while busy, SHALL be ignored and set err.
REQ-009 FSM states SHALL be: IDLE, SETUP, RX_WAIT, BIT_LO, BIT_HI, HOLD.
REQ-010 CMD 1 or 2 written in cycle N SHALL set busy, nrf_cs (CONFIG) or nrf_ce (TX), and nrf_data_oe at N+1, and enter SETUP for CS_SETUP cycles.
REQ-011 CMD 3 SHALL raise nrf_ce, hold nrf_data_oe=0, and wait in RX_WAIT until nrf_dr1 is sampled 1, then SETUP.
REQ-012 Each bit SHALL occupy BIT_LO (nrf_clk1=0, CLK_DIV cycles, data_o updated on entry) then BIT_HI (nrf_clk1=1, CLK_DIV cycles), MSB first, bytes buf[0..LEN-1].
REQ-013 RX SHALL sample nrf_data_i on the last BIT_HI cycle into buf[byte][bit].
REQ-014 After the last bit, HOLD SHALL last CLK_DIV cycles with nrf_clk1=0, then deassert nrf_cs/nrf_ce and nrf_data_oe, clear busy, set done, and return to IDLE.
REQ-015 Completion SHALL clear wptr for CONFIG/TX and clear rptr for RX.
REQ-016 CMD 0 in any state SHALL reach IDLE next cycle with all nrf_* outputs 0, busy=0, done unchanged, and buffer contents unchanged.
REQ-017 irq SHALL equal done & IRQEN[0], registered.
REQ-018 A W1C of done in the same cycle as completion SHALL leave done set.

Reset
REQ-019 reset_n low SHALL force IDLE, readdata=0, all nrf_* outputs=0, irq=0, and clear LEN, IRQEN, wptr, rptr, and STATUS flags; buffer contents need not be reset.

Structure
REQ-020 Package nf2401_seq_pkg SHALL hold the state enum, register addresses, and command codes.
REQ-021 Buffer SHALL be sub-module nf2401_seq_buf: BUF_DEPTH x 8, one write port and one read port, muxed between CPU and engine.

Verification
REQ-022 CONFIG: TXDATA 0xA5, 0x3C; LEN=2; CMD=1 -> nrf_cs high for 8+128+4 cycles; 16 CLK1 rises with DATA=1010010100111100; then done=1.
REQ-023 TX: IRQEN=1; TXDATA 0x81; LEN=1; CMD=2 -> nrf_ce pulse; 8 CLK1 rises with DATA 10000001; irq=1 after nrf_ce falls.
REQ-024 RX: LEN=2; CMD=3; model asserts nrf_dr1 at +50 and drives 0x5A, 0xC3 -> nrf_data_oe=0 throughout; RXDATA reads 0x5A, 0xC3, then 0x00.
REQ-025 Abort: CMD=0 at the 5th CLK1 rise of a 4-byte TX -> next cycle all nrf_* outputs 0, busy 0, done 0; a new CMD=2 is accepted.
REQ-026 Errors: 33 TXDATA writes -> ovf=1, wptr=32; CMD=2 while busy -> err=1, transfer unaffected.
REQ-027 Reset asserted mid-RX shift -> all outputs 0 asynchronously; after release, STATUS reads 0x00 (with nrf_dr1 low).
